// File: rtl/vending_control_if.sv
// Front-panel / coin-acceptor inputs and transaction report outputs of the vending controller.
interface vending_control_if;
    logic       start;
    logic       done_money;
    logic       cancel;
    logic       continue_buy;
    logic [1:0] item_in;
    logic [2:0] money;
    logic       done;
    logic       end_trans;
    logic [7:0] price;
    logic [7:0] sum_money;
    logic [1:0] item_select;
    logic [2:0] state;

    modport master (
        output start, done_money, cancel, continue_buy, item_in, money,
        input  done, end_trans, price, sum_money, item_select, state
    );

    modport slave (
        input  start, done_money, cancel, continue_buy, item_in, money,
        output done, end_trans, price, sum_money, item_select, state
    );
endinterface

// File: rtl/vending_control.sv
// Vending transaction FSM: item selection with stock check, money accumulation,
// price compare, and a Moore-decoded purchase/refund report in RETURN_CHANGE.
module vending_control #(
    parameter logic [7:0] PRICE0     = 8'd5,
    parameter logic [7:0] PRICE1     = 8'd5,
    parameter logic [7:0] PRICE2     = 8'd10,
    parameter logic [7:0] PRICE3     = 8'd15,
    parameter logic [3:0] STOCK_INIT = 4'd3
) (
    input logic         clk,
    input logic         reset_n,
    vending_control_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        SELECT        = 3'd1,
        RECEIVE_MONEY = 3'd2,
        COMPARE       = 3'd3,
        PROCESS       = 3'd4,
        RETURN_CHANGE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      acc;
    logic [1:0]      item_q;
    logic            purchase;
    logic [3:0][3:0] stock;
    logic [7:0]      item_price;
    logic [8:0]      acc_sum;
    logic            enough_money;
    logic            in_stock;

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = PRICE0;
            2'd1:    price_of = PRICE1;
            2'd2:    price_of = PRICE2;
            default: price_of = PRICE3;
        endcase
    endfunction

    assign item_price   = price_of(item_q);
    assign enough_money = (acc >= item_price);
    assign in_stock     = (stock[bus.item_in] != 4'd0);
    assign acc_sum      = {1'b0, acc} + {6'd0, bus.money};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (bus.start) state_d = SELECT;
            SELECT: begin
                // cancel takes priority over an out-of-stock selection
                if (bus.cancel)    state_d = IDLE;
                else if (in_stock) state_d = RECEIVE_MONEY;
            end
            RECEIVE_MONEY: if (bus.done_money) state_d = COMPARE;
            COMPARE:       state_d = enough_money ? RETURN_CHANGE : PROCESS;
            PROCESS:       state_d = bus.cancel ? RETURN_CHANGE : RECEIVE_MONEY;
            RETURN_CHANGE: state_d = bus.continue_buy ? SELECT : IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= 8'd0;
            item_q   <= 2'd0;
            purchase <= 1'b0;
            stock    <= {4{STOCK_INIT}};
        end else begin
            case (state_q)
                SELECT: begin
                    acc <= 8'd0;
                    if (!bus.cancel && in_stock) item_q <= bus.item_in;
                end
                RECEIVE_MONEY: acc <= acc_sum[8] ? 8'hFF : acc_sum[7:0];
                COMPARE: begin
                    if (enough_money) begin
                        stock[item_q] <= stock[item_q] - 4'd1;
                        purchase      <= 1'b1;
                    end
                end
                PROCESS: if (bus.cancel) purchase <= 1'b0;
                default: ;
            endcase
        end
    end

    // Report is valid only while the transaction result is being presented
    logic report;
    assign report          = (state_q == RETURN_CHANGE);
    assign bus.state       = state_q;
    assign bus.end_trans   = report;
    assign bus.done        = report && purchase;
    assign bus.sum_money   = report ? acc : 8'd0;
    assign bus.price       = (report && purchase) ? item_price : 8'd0;
    assign bus.item_select = (report && purchase) ? item_q : 2'd0;
endmodule

// File: tb/tb_vending_control.sv
// Directed bench for vending_control: selection, cancel, refund, purchase,
// saturation, stock exhaustion and asynchronous reset.
module tb_vending_control;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    vending_control_if bus ();

    vending_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic d, input logic e,
                              input logic [7:0] s, input logic [7:0] p, input logic [1:0] it);
        check({tag, ".done"},        32'(bus.done),        32'(d));
        check({tag, ".end_trans"},   32'(bus.end_trans),   32'(e));
        check({tag, ".sum_money"},   32'(bus.sum_money),   32'(s));
        check({tag, ".price"},       32'(bus.price),       32'(p));
        check({tag, ".item_select"}, 32'(bus.item_select), 32'(it));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.done_money = 0; bus.cancel = 0;
        bus.continue_buy = 0; bus.item_in = 0; bus.money = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        #2;
        reset_n = 1;
        #1;
    endtask

    // From SELECT: buy item `it` feeding `m` per cycle for `n` cycles, then check the report.
    task automatic buy(input logic [1:0] it, input logic [2:0] m, input int n,
                       input logic [7:0] exp_sum, input logic [7:0] exp_price, input string tag);
        bus.item_in = it;
        tick();
        check({tag, ".recv"}, 32'(bus.state), 2);
        bus.money = m;
        for (int i = 0; i < n; i++) begin
            bus.done_money = (i == n - 1);
            tick();
        end
        bus.money = 0; bus.done_money = 0;
        check({tag, ".cmp"}, 32'(bus.state), 3);
        tick();
        check({tag, ".ret"}, 32'(bus.state), 5);
        check_outs(tag, 1, 1, exp_sum, exp_price, it);
        bus.continue_buy = 1;
        tick();
        bus.continue_buy = 0;
        check({tag, ".again"}, 32'(bus.state), 1);
    endtask

    initial begin
        idle_inputs();
        #3;
        check("rst.state", 32'(bus.state), 0);
        check_outs("rst", 0, 0, 0, 0, 0);
        reset_n = 1;
        tick();
        tick();
        check("idle.hold", 32'(bus.state), 0);
        bus.start = 1;
        tick();
        check("idle.start", 32'(bus.state), 1);
        check_outs("sel", 0, 0, 0, 0, 0);

        // cancel in SELECT
        do_reset();
        bus.start = 1; bus.cancel = 1;
        tick(); tick();
        check("sel.cancel", 32'(bus.state), 0);
        check_outs("sel.cancel", 0, 0, 0, 0, 0);

        // select item 1
        do_reset();
        bus.start = 1; bus.item_in = 1;
        tick(); tick();
        check("sel.item1", 32'(bus.state), 2);
        check_outs("recv", 0, 0, 0, 0, 0);

        // insufficient money, retry, then refund
        do_reset();
        bus.start = 1;
        tick(); bus.start = 0;
        tick();
        bus.money = 1; bus.done_money = 1;
        tick();
        bus.money = 0; bus.done_money = 0;
        check("low.cmp", 32'(bus.state), 3);
        tick();
        check("low.proc", 32'(bus.state), 4);
        check_outs("proc", 0, 0, 0, 0, 0);
        tick();
        check("low.retry", 32'(bus.state), 2);
        bus.done_money = 1; bus.cancel = 1;   // cancel ignored in RECEIVE_MONEY
        tick();
        bus.done_money = 0;
        check("low.cmp2", 32'(bus.state), 3);
        tick();
        check("low.proc2", 32'(bus.state), 4);
        tick();
        bus.cancel = 0;
        check("refund.state", 32'(bus.state), 5);
        check_outs("refund", 0, 1, 1, 0, 0);
        tick();
        check("refund.idle", 32'(bus.state), 0);
        check_outs("refund.after", 0, 0, 0, 0, 0);

        // purchase of item 1 with two coins
        do_reset();
        bus.start = 1;
        tick(); bus.start = 0;
        bus.item_in = 1;
        tick();
        bus.money = 4;
        tick();
        bus.money = 2; bus.done_money = 1;
        tick();
        bus.money = 0; bus.done_money = 0;
        check("buy1.cmp", 32'(bus.state), 3);
        tick();
        check("buy1.state", 32'(bus.state), 5);
        check_outs("buy1", 1, 1, 6, 5, 1);
        bus.continue_buy = 1;
        tick();
        bus.continue_buy = 0;
        check("buy1.cont", 32'(bus.state), 1);
        check_outs("buy1.after", 0, 0, 0, 0, 0);

        // exhaust item 2 (exactly 10 each time), then saturate on item 3
        buy(2, 5, 2, 10, 10, "buy2a");
        buy(2, 5, 2, 10, 10, "buy2b");
        buy(2, 5, 2, 10, 10, "buy2c");
        bus.item_in = 2;
        tick();
        check("oos.stay", 32'(bus.state), 1);
        tick();
        check("oos.stay2", 32'(bus.state), 1);
        buy(3, 7, 37, 255, 15, "sat");
        bus.item_in = 2; bus.cancel = 1;
        tick();
        bus.cancel = 0;
        check("oos.cancel", 32'(bus.state), 0);

        // async reset mid-RECEIVE restores stock
        bus.start = 1; bus.item_in = 0;
        tick(); bus.start = 0;
        tick();
        bus.money = 3;
        tick();
        check("mid.recv", 32'(bus.state), 2);
        #2;
        reset_n = 0;
        #1;
        check("async.state", 32'(bus.state), 0);
        check_outs("async", 0, 0, 0, 0, 0);
        reset_n = 1;
        idle_inputs();
        tick();
        bus.start = 1; bus.item_in = 2;
        tick(); bus.start = 0;
        tick();
        check("restock", 32'(bus.state), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vending_control.md
Name: vending_control

Overview:
- Vending-machine transaction controller: single-module FSM that sequences IDLE → SELECT → RECEIVE_MONEY → COMPARE → PROCESS/RETURN_CHANGE.
- Holds a per-item price table and per-item stock counters, and accumulates inserted money.
- Reports the completed transaction (total inserted money, price, item, done/end flags) during RETURN_CHANGE.
- Sits between the front-panel/coin-acceptor inputs and the dispense/change logic.

Parameters:
- PRICE0, 5, price of item 0 (8-bit).
- PRICE1, 5, price of item 1.
- PRICE2, 10, price of item 2.
- PRICE3, 15, price of item 3.
- STOCK_INIT, 3, initial stock count of every item (4-bit counters).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin transaction (sampled in IDLE).
- done_money  input  1  customer finished inserting money (sampled in RECEIVE_MONEY).
- cancel  input  1  abort request (sampled in SELECT and PROCESS).
- continue_buy  input  1  start another purchase (sampled in RETURN_CHANGE).
- item_in  input  2  selected item index (sampled in SELECT).
- money  input  3  unsigned coin value added each RECEIVE_MONEY cycle (0 = none).
- done  output  1  purchase succeeded.
- end_trans  output  1  transaction ended (purchase or refund).
- price  output  8  price of the purchased item.
- sum_money  output  8  total money inserted in this transaction.
- item_select  output  2  purchased item index.
- state  output  3  current state encoding.

Behaviour:
- State encodings: IDLE=0, SELECT=1, RECEIVE_MONEY=2, COMPARE=3, PROCESS=4, RETURN_CHANGE=5. Unused codes 6 and 7 return to IDLE on the next clock.
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE; accumulator=0; latched item=0; all stock counters=STOCK_INIT.
  - All outputs 0 immediately.
- Outputs are Moore-decoded from the current state and internal registers, with no extra latency.
  - In every state except RETURN_CHANGE: done=0, end_trans=0, sum_money=0, price=0, item_select=0.
- IDLE:
  - start=1 → SELECT.
  - Otherwise stay in IDLE.
- SELECT:
  - On entry, the accumulator is cleared.
  - cancel=1 → IDLE. Cancel wins over out_stock.
  - Else if stock[item_in]==0 (out_stock) → stay in SELECT.
  - Else → RECEIVE_MONEY, and item_in is latched as the transaction item.
- RECEIVE_MONEY:
  - Each clock: accumulator += money, saturating at 255.
  - done_money=1 → COMPARE. The money value present on that same edge is still added.
  - cancel is ignored in this state.
- COMPARE:
  - enough_money = accumulator ≥ price[item].
  - enough_money=1 → RETURN_CHANGE as a purchase; stock[item] decrements by 1 on this edge.
  - enough_money=0 → PROCESS.
- PROCESS:
  - cancel=1 → RETURN_CHANGE as a refund.
  - cancel=0 → RECEIVE_MONEY; the accumulator is retained.
- RETURN_CHANGE:
  - Purchase: done=1, end_trans=1, sum_money=accumulator, price=price[item], item_select=item.
  - Refund: done=0, end_trans=1, sum_money=accumulator, price=0, item_select=0.
  - Next edge: continue_buy=1 → SELECT; else → IDLE. Outputs drop to 0 on that edge.
- A purchase/refund flag is registered on the COMPARE/PROCESS exit edge.
- Change owed (sum_money − price) is computed downstream; this block does not output it.

Test Plan:
- Reset, then start=0 for 1 clock → state=0, all outputs 0. Then start=1, 1 clock → state=1, outputs 0.
- From reset: start=1, item_in=0, cancel=1, 2 clocks → state=0, outputs 0.
- From reset: start=1, item_in=1, cancel=0, 2 clocks → state=2, outputs 0.
- From reset: item 0, then money=1 with done_money=1 → COMPARE, then state=4 (1 < 5). Next clock cancel=0 → state=2; or cancel=1 → state=5 with end_trans=1, done=0, sum_money=1.
- Purchase: item 1; RECEIVE cycle 1 money=4, done_money=0; cycle 2 money=2, done_money=1 → COMPARE → RETURN_CHANGE with done=1, end_trans=1, sum_money=6, price=5, item_select=1. Next clock: continue_buy=1 → state=1, or continue_buy=0 → state=0; outputs 0 in both cases.
- Stock exhaustion (STOCK_INIT=3): buy item 2 three times, then select item 2 → state stays 1. Apply reset_n=0 mid-RECEIVE → state=0 asynchronously; item 2 is selectable again afterwards.
